// File: rtl/edh_pic_reader_pkg.sv
// ---------------------------------------------------------------------------
// edh_pkg
// Shared definitions for the EDH picture reader:
//   state_e          - reader FSM states
//   AXI_SIZE_16B     - AXI beat size code for 16-byte beats
//   AXI_BURST_INCR   - AXI incrementing burst type
//   AXI_RESP_OKAY    - AXI OKAY response code
//   BASE_ADDR        - DRAM byte address of picture 0
//   PIC_BYTES        - byte stride between consecutive pictures
//   BURST_BEATS      - beats fetched per picture
// ---------------------------------------------------------------------------
package edh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        DONE
    } state_e;

    localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    localparam logic [31:0] BASE_ADDR      = 32'h0004_0000;
    localparam int          PIC_BYTES      = 4096;
    localparam int          BURST_BEATS    = 256;

endpackage

// File: rtl/edh_pic_reader_skid_buf.sv
// ---------------------------------------------------------------------------
// edh_skid_buf
// Two-entry valid/ready buffer between the AXI read data channel and the
// EDH stream. The upstream ready (can_accept_o) comes straight from a flop,
// computed from the next-cycle occupancy, so a beat arriving while the
// downstream stalls always has a free slot to land in.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   accept_en_i   - upstream may be granted ready next cycle
//   push_i        - a beat is transferred in this cycle
//   push_data_i   - beat payload
//   can_accept_o  - registered upstream ready
//   pop_valid_o   - buffer holds at least one beat
//   pop_data_o    - oldest beat
//   pop_ready_i   - downstream takes the oldest beat
//   empty_o       - buffer holds no beat
// ---------------------------------------------------------------------------
module edh_skid_buf #(
    parameter int WIDTH = 136
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_en_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             can_accept_o,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    input  logic             pop_ready_i,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             can_accept_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is dropped rather than overwriting the head.
    assign do_push      = push_i && (count_q != 2'd2);
    assign do_pop       = pop_valid_o && pop_ready_i;

    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign empty_o      = (count_q == 2'd0);
    assign can_accept_o = can_accept_q;

    // Simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Ready for next cycle is derived from next-cycle occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            can_accept_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q      <= count_d;
            can_accept_q <= accept_en_i && (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/edh_pic_reader.sv
// ---------------------------------------------------------------------------
// edh_pic_reader
// AXI4 read-burst front end for the EDH core. A start request fetches one
// picture (BURST_BEATS beats of DATA_WIDTH bits) from DRAM and streams the
// beats, tagged with their index, to the erosion/dilation/histogram path.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, pic_no       - one-cycle request and picture index (IDLE only)
//   rd_busy, done, err  - status to the EDH controller; err valid with done
//   ar*_m_inf           - AXI read address channel (master side)
//   r*_m_inf            - AXI read data channel (master side)
//   out_data, out_idx,
//   out_valid, out_ready - beat stream to the EDH datapath
// ---------------------------------------------------------------------------
module edh_pic_reader #(
    parameter int                    ID_WIDTH    = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 128,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(edh_pkg::BASE_ADDR),
    parameter int                    PIC_BYTES   = edh_pkg::PIC_BYTES,
    parameter int                    BURST_BEATS = edh_pkg::BURST_BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            pic_no,
    output logic                  rd_busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [7:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            out_idx,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import edh_pkg::*;

    localparam logic [7:0]            LastBeat  = 8'(BURST_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] PicStride = ADDR_WIDTH'(PIC_BYTES);

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [ADDR_WIDTH-1:0]   araddr_d;
    logic                    arvalid_q;
    logic                    arvalid_d;
    logic                    err_q;
    logic                    err_d;
    logic [7:0]              beat_cnt_q;
    logic [7:0]              beat_cnt_d;

    logic                    rd_push;
    logic                    buf_accept_en;
    logic                    buf_can_accept;
    logic                    buf_empty;
    logic [DATA_WIDTH+7:0]   buf_data;
    logic                    unused_rid;

    // Read IDs are not checked: only one burst is ever outstanding.
    assign unused_rid = ^rid_m_inf;

    assign rd_push = rvalid_m_inf && buf_can_accept;

    // Next-state logic: address issue, beat counting, error capture.
    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    araddr_d  = BASE_ADDR + (ADDR_WIDTH'(pic_no) * PicStride);
                    arvalid_d = 1'b1;
                    err_d     = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && arready_m_inf) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (rd_push) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (rresp_m_inf != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // A missing or premature rlast both end the burst here;
                    // beats the slave still holds are never requested.
                    if (beat_cnt_q == LastBeat) begin
                        if (!rlast_m_inf) begin
                            err_d = 1'b1;
                        end
                        state_d = DRAIN;
                    end else if (rlast_m_inf) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (buf_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rready is only granted while the next cycle is still in DATA.
    assign buf_accept_en = (state_d == DATA);

    // State and AXI address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            err_q      <= 1'b0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    edh_skid_buf #(
        .WIDTH (DATA_WIDTH + 8)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept_en_i  (buf_accept_en),
        .push_i       (rd_push),
        .push_data_i  ({rdata_m_inf, beat_cnt_q}),
        .can_accept_o (buf_can_accept),
        .pop_valid_o  (out_valid),
        .pop_data_o   (buf_data),
        .pop_ready_i  (out_ready),
        .empty_o      (buf_empty)
    );

    assign out_data      = buf_data[DATA_WIDTH+7:8];
    assign out_idx       = buf_data[7:0];

    assign rd_busy       = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign err           = err_q;

    assign arid_m_inf    = '0;
    assign araddr_m_inf  = araddr_q;
    assign arlen_m_inf   = LastBeat;
    assign arsize_m_inf  = AXI_SIZE_16B;
    assign arburst_m_inf = AXI_BURST_INCR;
    assign arvalid_m_inf = arvalid_q;
    assign rready_m_inf  = buf_can_accept;

endmodule

// File: doc/edh_pic_reader.md
Name: edh_pic_reader

Overview:
- AXI4 read-burst front end for the EDH core.
- On a start request it fetches one 4 KB picture (256 beats × 128 b) from DRAM over the read address and read data channels.
- Beats are delivered in order to the downstream erosion/dilation/histogram datapath on a valid/ready stream, through a 2-entry skid buffer so `rready_m_inf` is registered.
- Reports completion and protocol errors to the EDH top-level controller.

Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 128, AXI data / stream width.
- BASE_ADDR, 32'h0004_0000, DRAM address of picture 0.
- PIC_BYTES, 4096, stride between pictures.
- BURST_BEATS, 256, beats per picture.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- pic_no  in  4  picture index, sampled with start
- rd_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last beat leaves stream
- err  out  1  sticky per transfer; valid with done
- arid_m_inf  out  ID_WIDTH  constant 0
- araddr_m_inf  out  ADDR_WIDTH  BASE_ADDR + pic_no*PIC_BYTES
- arlen_m_inf  out  8  BURST_BEATS-1 (8'd255)
- arsize_m_inf  out  3  3'b100
- arburst_m_inf  out  2  2'b01 INCR
- arvalid_m_inf  out  1  address valid
- arready_m_inf  in  1  address ready
- rid_m_inf  in  ID_WIDTH  ignored
- rdata_m_inf  in  DATA_WIDTH  read data
- rresp_m_inf  in  2  response
- rlast_m_inf  in  1  last beat
- rvalid_m_inf  in  1  data valid
- rready_m_inf  out  1  data ready, registered
- out_data  out  DATA_WIDTH  beat to EDH core
- out_idx  out  8  beat index 0..255
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

Behaviour:
- Reset values: all outputs 0 except the constant AXI fields (arid/arlen/arsize/arburst), which always hold their constant values. `araddr_m_inf` resets to 0.
- IDLE:
  - `start` latches pic_no, drives araddr, sets `rd_busy` and `arvalid_m_inf` on the next edge, and clears err.
  - Goes to ADDR.
- ADDR:
  - `arvalid` holds, and `araddr` stays stable, until `arvalid && arready`.
  - Then drops arvalid and goes to DATA.
  - Minimum latency start→arvalid is 1 cycle.
- DATA:
  - `rready_m_inf = 1` when the skid buffer has ≥1 free entry, registered from the next-state occupancy.
  - Each `rvalid && rready` handshake pushes {rdata, beat_cnt} into the skid buffer and increments the 8-bit beat_cnt.
  - If `rresp != 0` on any beat, err is set.
  - At beat_cnt == 255 handshake:
    - If `rlast == 0`, err is set.
    - rready deasserts and the state goes to DRAIN.
  - If `rlast == 1` at beat_cnt < 255, err is set and the state goes to DRAIN immediately; remaining beats are not requested.
- DRAIN: waits until the skid buffer is empty (last `out_valid && out_ready`), then goes to DONE.
- DONE: pulses `done` for 1 cycle, `rd_busy` drops the same cycle, then returns to IDLE.
  - A start in the DONE cycle is ignored.
  - A start may be accepted in the cycle after DONE.
- Stream rules:
  - `out_valid` stays asserted with stable out_data/out_idx until out_ready.
  - Order is preserved, with no bubble when out_ready is held high.
  - Throughput is 1 beat/cycle.
- start while rd_busy is ignored; pic_no is not resampled.
- Address arithmetic: `araddr = BASE_ADDR + {pic_no, 12'h000}`, evaluated at ADDR_WIDTH bits. Picture 15 gives 0x0004_F000.
- Reset mid-operation (any state): asynchronously returns to IDLE, empties the skid buffer, and drops arvalid/rready/out_valid. No memory of the partial burst is kept.
- Simultaneous push and pop in the skid buffer when full-1 keeps occupancy; rready stays high.

Decomposition:
- Package edh_pkg holds:
  - state enum {IDLE, ADDR, DATA, DRAIN, DONE};
  - AXI constants AXI_SIZE_16B = 3'b100, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00;
  - BASE_ADDR and PIC_BYTES.
- One sub-module, edh_skid_buf: 2-entry valid/ready buffer, width DATA_WIDTH+8, exposing a registered `can_accept`.

Test Plan:
1. pic_no = 3, arready 1 cycle after arvalid, rvalid continuous, out_ready = 1 → araddr = 0x0004_3000, arlen = 255, 256 beats out with out_idx 0..255 in order, one done pulse, err = 0.
2. Random out_ready at 30% duty with rvalid continuous → data matches DRAM, no beat lost or duplicated, rready never high while the buffer is full, out_data stable while stalled.
3. rresp = 2'b10 on beat 17 → all 256 beats delivered, err = 1 at done.
4. rlast asserted on beat 99 → DRAIN entered, 100 beats delivered, err = 1; next: rlast missing on beat 255 → err = 1.
5. Second start during DATA, and start held through DONE → ignored, exactly one burst per accepted start, araddr unchanged; the next start after IDLE is accepted.
6. rst_n low during beat 120 → arvalid/rready/out_valid/rd_busy = 0 immediately. After release, a start with pic_no = 15 gives araddr = 0x0004_F000 and a clean 256-beat transfer.
